// File: rtl/burst_slave.sv
// Burst responder: accepts one read/write request, then streams that many 32-bit beats
// into or out of a 16-word register file with 4-bit wrapping addresses.
module burst_slave (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_wr,
    input  logic [3:0]  io_req_addr,
    input  logic [3:0]  io_req_len,
    input  logic        io_wvalid,
    input  logic [31:0] io_wdata,
    output logic        io_wready,
    output logic        io_rvalid,
    output logic [31:0] io_rdata,
    input  logic        io_rready,
    output logic        io_rlast,
    output logic        io_done
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e      state_q;
    logic [3:0]  addr_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [31:0] mem_q [16];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= 4'd0;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (io_req_valid) begin
                        addr_q <= io_req_addr;
                        cnt_q  <= io_req_len;
                        wr_q   <= io_req_wr;
                        if (io_req_len == 4'd0) begin
                            state_q <= StResp;
                        end else if (io_req_wr) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    if (io_wvalid) begin
                        mem_q[addr_q] <= io_wdata;
                        addr_q        <= addr_q + 4'd1;
                        cnt_q         <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= StResp;
                        end
                    end
                end
                StRead: begin
                    if (io_rready) begin
                        addr_q <= addr_q + 4'd1;
                        cnt_q  <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so they follow an async reset immediately.
    assign io_req_ready = (state_q == StIdle);
    assign io_wready    = (state_q == StWrite);
    assign io_rvalid    = (state_q == StRead);
    assign io_rlast     = (state_q == StRead) && (cnt_q == 4'd1);
    assign io_done      = (state_q == StResp);
    assign io_rdata     = io_rvalid ? mem_q[addr_q] : 32'd0;

endmodule

// File: tb/tb_burst_slave.sv
// Directed and randomized bench for burst_slave, checked against a word-array memory model.
module tb_burst_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic        io_req_wr = 1'b0;
    logic [3:0]  io_req_addr = 4'd0;
    logic [3:0]  io_req_len = 4'd0;
    logic        io_wvalid = 1'b0;
    logic [31:0] io_wdata = 32'd0;
    logic        io_wready;
    logic        io_rvalid;
    logic [31:0] io_rdata;
    logic        io_rready = 1'b0;
    logic        io_rlast;
    logic        io_done;

    burst_slave dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_wr    (io_req_wr),
        .io_req_addr  (io_req_addr),
        .io_req_len   (io_req_len),
        .io_wvalid    (io_wvalid),
        .io_wdata     (io_wdata),
        .io_wready    (io_wready),
        .io_rvalid    (io_rvalid),
        .io_rdata     (io_rdata),
        .io_rready    (io_rready),
        .io_rlast     (io_rlast),
        .io_done      (io_done)
    );

    always #5 clock = ~clock;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] mem_m [16];
    logic [31:0] wbuf [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_req_ready"}, io_req_ready, 1);
        chk({tag, "_wready"}, io_wready, 0);
        chk({tag, "_rvalid"}, io_rvalid, 0);
        chk({tag, "_rlast"}, io_rlast, 0);
        chk({tag, "_done"}, io_done, 0);
        chk({tag, "_rdata"}, io_rdata, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic accept(input logic wr, input logic [3:0] a, input logic [3:0] len,
                          input bit pre);
        if (!pre) begin
            chk("accept_req_ready", io_req_ready, 1);
            io_req_valid = 1'b1;
            io_req_wr    = wr;
            io_req_addr  = a;
            io_req_len   = len;
        end
        @(negedge clock);
        io_req_valid = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        chk({tag, "_done_pulse"}, io_done, 1);
        chk({tag, "_resp_ready"}, io_req_ready, 0);
        chk({tag, "_resp_rvalid"}, io_rvalid, 0);
        chk({tag, "_resp_wready"}, io_wready, 0);
        chk({tag, "_resp_rdata"}, io_rdata, 0);
        @(negedge clock);
        chk({tag, "_done_end"}, io_done, 0);
        chk({tag, "_ready_again"}, io_req_ready, 1);
    endtask

    task automatic write_burst(input logic [3:0] a, input logic [3:0] len,
                               input logic [15:0] gaps, input int abort_at, input bit hold);
        accept(1'b1, a, len, 1'b0);
        if (hold) begin
            io_req_valid = 1'b1;
            io_req_wr    = 1'b0;
            io_req_addr  = a + 4'd5;
            io_req_len   = 4'd2;
        end
        for (int i = 0; i < int'(len); i++) begin
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1 idle_outputs("mid_reset");
                clear_model();
                io_wvalid = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    chk("abort_no_done", io_done, 0);
                    chk("abort_idle", io_req_ready, 1);
                end
                return;
            end
            if (gaps[i]) begin
                io_wvalid = 1'b0;
                io_wdata  = $urandom;
                chk("wr_gap_wready", io_wready, 1);
                chk("wr_gap_done", io_done, 0);
                @(negedge clock);
            end
            chk("wr_wready", io_wready, 1);
            chk("wr_busy", io_req_ready, 0);
            chk("wr_no_done", io_done, 0);
            io_wvalid = 1'b1;
            io_wdata  = wbuf[i];
            mem_m[(int'(a) + i) % 16] = wbuf[i];
            @(negedge clock);
        end
        io_wvalid = 1'b0;
        finish_burst("wr");
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [3:0] len,
                              input int stall_beat, input int stall_n, input bit pre);
        logic [31:0] exp;
        logic        last;
        accept(1'b0, a, len, pre);
        for (int i = 0; i < int'(len); i++) begin
            exp  = mem_m[(int'(a) + i) % 16];
            last = (i == int'(len) - 1);
            if (i == stall_beat) begin
                repeat (stall_n) begin
                    io_rready = 1'b0;
                    chk("rd_stall_rvalid", io_rvalid, 1);
                    chk("rd_stall_rdata", io_rdata, exp);
                    chk("rd_stall_rlast", io_rlast, last);
                    chk("rd_stall_done", io_done, 0);
                    @(negedge clock);
                end
            end
            io_rready = 1'b1;
            chk("rd_rvalid", io_rvalid, 1);
            chk("rd_rdata", io_rdata, exp);
            chk("rd_rlast", io_rlast, last);
            chk("rd_busy", io_req_ready, 0);
            @(negedge clock);
        end
        io_rready = 1'b0;
        finish_burst("rd");
    endtask

    initial begin
        clear_model();
        #3 idle_outputs("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        idle_outputs("post_reset");

        read_burst(4'd0, 4'd0, -1, 0, 1'b0);
        read_burst(4'd0, 4'd15, -1, 0, 1'b0);
        read_burst(4'd15, 4'd1, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        write_burst(4'd6, 4'd4, 16'd0, -1, 1'b0);
        read_burst(4'd6, 4'd4, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(4'd14, 4'd4, 16'd0, -1, 1'b0);
        read_burst(4'd0, 4'd2, -1, 0, 1'b0);
        read_burst(4'd14, 4'd2, -1, 0, 1'b0);

        // wvalid pattern 1-0-1-0-1, then a 2-cycle rready stall on the middle beat
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        write_burst(4'd8, 4'd3, 16'b0110, -1, 1'b0);
        read_burst(4'd8, 4'd3, 1, 2, 1'b0);

        write_burst(4'd6, 4'd0, 16'd0, -1, 1'b0);
        read_burst(4'd6, 4'd4, -1, 0, 1'b0);

        // Request held high with read fields (addr 14, len 2) during a write burst
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        write_burst(4'd9, 4'd3, 16'd0, -1, 1'b1);
        read_burst(4'd14, 4'd2, -1, 0, 1'b1);

        repeat (8) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            write_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        16'($urandom), -1, 1'b0);
            read_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
        end

        #2 reset = 1'b0;
        #1 idle_outputs("async_reset");
        clear_model();
        @(negedge clock);
        reset = 1'b1;
        read_burst(4'd0, 4'd15, -1, 0, 1'b0);
        read_burst(4'd15, 4'd1, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = $urandom | 32'd1;
        write_burst(4'd2, 4'd4, 16'd0, 2, 1'b0);
        read_burst(4'd2, 4'd4, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
